// File: rtl/pvz_pkg.sv
// Shared Plants vs Zombies game constants: scheduler states, lane width,
// wave limit and the LFSR setup reused by other randomised game blocks.
package pvz_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_COOLDOWN,
    S_DRAIN,
    S_OVER
  } sched_state_t;

  localparam int LANE_W   = 3;
  localparam int MAX_WAVE = 15;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci feedback taps 8,6,5,4 expressed as a mask over bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/zombie_lane_picker.sv
// Chooses the lane for the next zombie: round-robin by default, or an
// 8-bit LFSR when ZOMBIE_LFSR_LANE_EN is defined.
module zombie_lane_picker
  import pvz_pkg::*;
#(
  parameter int NUM_LANES = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  input  logic              sample,
  output logic [LANE_W-1:0] lane
);

`ifdef ZOMBIE_LFSR_LANE_EN
  localparam logic [LANE_W-1:0] LANES = LANE_W'(NUM_LANES);

  logic [7:0]        lfsr;
  logic [LANE_W-1:0] raw;
  logic [LANE_W-1:0] folded;
  logic              unused_advance;

  assign unused_advance = advance;
  assign raw            = lfsr[2:0];
  // Out-of-range draws fold back onto the lawn instead of being re-rolled.
  assign folded         = (raw >= LANES) ? raw - LANES : raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
      lane <= '0;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      if (sample) lane <= folded;
    end
  end
`else
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  logic unused_sample;

  assign unused_sample = sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane <= '0;
    end else if (advance) begin
      lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
    end
  end
`endif

endmodule

// File: rtl/zombie_wave_scheduler.sv
// Zombie wave scheduler: issues spawns, tracks live and killed zombies and
// advances waves. Define ZOMBIE_LFSR_LANE_EN for pseudo-random lane choice.
module zombie_wave_scheduler
  import pvz_pkg::*;
#(
  parameter int NUM_LANES      = 5,
  parameter int MAX_ACTIVE     = 8,
  parameter int SPAWN_INTERVAL = 60,
  parameter int WAVE_SIZE_INIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              frame_tick,
  input  logic              kill,
  input  logic              breach,
  input  logic              spawn_ready,
  output logic              spawn_valid,
  output logic [LANE_W-1:0] spawn_lane,
  output logic [3:0]        active_count,
  output logic [15:0]       zombies_killed,
  output logic [3:0]        wave,
  output logic              wave_done,
  output logic              game_over
);

  localparam int               CNT_W      = $clog2(SPAWN_INTERVAL + 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(SPAWN_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       ACTIVE_CAP = 4'(MAX_ACTIVE);
  localparam logic [3:0]       LAST_WAVE  = 4'(MAX_WAVE);
  localparam logic [7:0]       WAVE_BASE  = 8'(WAVE_SIZE_INIT);

  sched_state_t     state;
  logic [CNT_W-1:0] cooldown;
  logic [7:0]       remaining;
  logic             playing;
  logic             accept;
  logic             kill_ok;
  logic             sample;

  assign playing = (state == S_SPAWN) || (state == S_COOLDOWN) || (state == S_DRAIN);
  assign accept  = (state == S_SPAWN) && spawn_valid && spawn_ready && !breach;
  assign kill_ok = playing && kill && (active_count != 4'd0);
  // A request is raised only with room on the lawn; the lane is captured on that edge.
  assign sample  = (state == S_SPAWN) && !spawn_valid && !breach && (active_count < ACTIVE_CAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cooldown       <= '0;
      remaining      <= '0;
      spawn_valid    <= 1'b0;
      active_count   <= '0;
      zombies_killed <= '0;
      wave           <= '0;
      wave_done      <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      wave_done <= 1'b0;
      // Same-cycle accept and kill cancel out in the live count.
      if (accept && !kill_ok)      active_count <= active_count + 4'd1;
      else if (kill_ok && !accept) active_count <= active_count - 4'd1;
      if (kill_ok && (zombies_killed != 16'hFFFF)) zombies_killed <= zombies_killed + 16'd1;

      if (playing && breach) begin
        state       <= S_OVER;
        spawn_valid <= 1'b0;
        game_over   <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_OVER: begin
            if (start) begin
              state          <= S_SPAWN;
              wave           <= 4'd1;
              remaining      <= WAVE_BASE;
              active_count   <= '0;
              zombies_killed <= '0;
              spawn_valid    <= 1'b0;
              game_over      <= 1'b0;
            end
          end
          S_SPAWN: begin
            if (accept) begin
              spawn_valid <= 1'b0;
              remaining   <= remaining - 8'd1;
              cooldown    <= COOL_LOAD;
              state       <= (remaining == 8'd1) ? S_DRAIN : S_COOLDOWN;
            end else if (sample) begin
              spawn_valid <= 1'b1;
            end
          end
          S_COOLDOWN: begin
            if (frame_tick) begin
              cooldown <= cooldown - CNT_ONE;
              if (cooldown <= CNT_ONE) state <= S_SPAWN;
            end
          end
          S_DRAIN: begin
            if (active_count == 4'd0) begin
              wave_done <= 1'b1;
              if (wave < LAST_WAVE) begin
                wave      <= wave + 4'd1;
                remaining <= WAVE_BASE + {4'd0, wave} + 8'd1;
                state     <= S_SPAWN;
              end else begin
                state     <= S_OVER;
                game_over <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  zombie_lane_picker #(
    .NUM_LANES(NUM_LANES)
  ) u_lane_picker (
    .clk    (clk),
    .reset_n(reset_n),
    .advance(accept),
    .sample (sample),
    .lane   (spawn_lane)
  );

endmodule

// File: tb/tb_zombie_wave_scheduler.sv
// Self-checking bench for zombie_wave_scheduler: a default-parameter instance
// plus a MAX_ACTIVE=2 instance for the live-zombie cap.
module tb_zombie_wave_scheduler;
  import pvz_pkg::*;

  localparam int SPAWN_INTERVAL_TB = 60;
  localparam int NUM_LANES_TB      = 5;

  typedef struct {
    logic kl;
    logic st;
    logic rdy;
    int   act;
    int   kills;
    int   wv;
    logic done;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        tick_en;
  logic        start, kill, breach, spawn_ready;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic [3:0]  active_count;
  logic [15:0] zombies_killed;
  logic [3:0]  wave;
  logic        wave_done, game_over;

  logic        s2_start, s2_kill, s2_ready;
  logic        s2_valid;
  logic [2:0]  s2_lane;
  logic [3:0]  s2_active;
  logic [15:0] s2_killed;
  logic [3:0]  s2_wave;
  logic        s2_done, s2_over;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          n2_acc   = 0;
  int          gap_ticks = 0;
  logic        gap_chk  = 1'b0;
  logic [2:0]  lane_q[$];
  vec_t        vecs[8];

  always #5 clk = ~clk;

  zombie_wave_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .frame_tick    (frame_tick),
    .kill          (kill),
    .breach        (breach),
    .spawn_ready   (spawn_ready),
    .spawn_valid   (spawn_valid),
    .spawn_lane    (spawn_lane),
    .active_count  (active_count),
    .zombies_killed(zombies_killed),
    .wave          (wave),
    .wave_done     (wave_done),
    .game_over     (game_over)
  );

  zombie_wave_scheduler #(
    .MAX_ACTIVE    (2),
    .SPAWN_INTERVAL(2)
  ) dut2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (s2_start),
    .frame_tick    (frame_tick),
    .kill          (s2_kill),
    .breach        (1'b0),
    .spawn_ready   (s2_ready),
    .spawn_valid   (s2_valid),
    .spawn_lane    (s2_lane),
    .active_count  (s2_active),
    .zombies_killed(s2_killed),
    .wave          (s2_wave),
    .wave_done     (s2_done),
    .game_over     (s2_over)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at a falling edge, scores any handshake that the
  // coming rising edge will complete, then waits for the next falling edge.
  task automatic applyStimulus(input logic st, input logic kl, input logic br, input logic rdy);
    logic [2:0] exp_lane;
    start       = st;
    kill        = kl;
    breach      = br;
    spawn_ready = rdy;
    frame_tick  = tick_en && !frame_tick;
    if (spawn_valid && spawn_ready) begin
      if (gap_chk && n_acc > 0) checkOutput("frames between spawns", gap_ticks, SPAWN_INTERVAL_TB);
      gap_ticks = 0;
      n_acc++;
      if (lane_q.size() == 0) begin
        checkOutput("spawn with empty scoreboard", int'(spawn_valid), 0);
      end else begin
        exp_lane = lane_q.pop_front();
        checkOutput("spawn lane", int'(spawn_lane), int'(exp_lane));
      end
    end else if (frame_tick) begin
      gap_ticks++;
    end
    if (s2_valid && s2_ready) n2_acc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    logic hold_bad;
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; breach = 1'b0; spawn_ready = 1'b0;
    frame_tick = 1'b0; tick_en = 1'b0;
    s2_start = 1'b0; s2_kill = 1'b0; s2_ready = 1'b0;

    vecs[0] = '{kl: 1'b1, st: 1'b0, rdy: 1'b0, act: 3, kills: 1, wv: 1, done: 1'b0};
    vecs[1] = '{kl: 1'b0, st: 1'b0, rdy: 1'b0, act: 3, kills: 1, wv: 1, done: 1'b0};
    vecs[2] = '{kl: 1'b1, st: 1'b0, rdy: 1'b0, act: 2, kills: 2, wv: 1, done: 1'b0};
    vecs[3] = '{kl: 1'b1, st: 1'b0, rdy: 1'b0, act: 1, kills: 3, wv: 1, done: 1'b0};
    vecs[4] = '{kl: 1'b0, st: 1'b1, rdy: 1'b0, act: 1, kills: 3, wv: 1, done: 1'b0};
    vecs[5] = '{kl: 1'b1, st: 1'b0, rdy: 1'b0, act: 0, kills: 4, wv: 1, done: 1'b0};
    vecs[6] = '{kl: 1'b0, st: 1'b0, rdy: 1'b0, act: 0, kills: 4, wv: 2, done: 1'b1};
    vecs[7] = '{kl: 1'b1, st: 1'b0, rdy: 1'b0, act: 0, kills: 4, wv: 2, done: 1'b0};

    @(negedge clk);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset spawn_valid", int'(spawn_valid), 0);
    checkOutput("reset spawn_lane", int'(spawn_lane), 0);
    checkOutput("reset active_count", int'(active_count), 0);
    checkOutput("reset zombies_killed", int'(zombies_killed), 0);
    checkOutput("reset wave", int'(wave), 0);
    checkOutput("reset wave_done", int'(wave_done), 0);
    checkOutput("reset game_over", int'(game_over), 0);
    checkOutput("reset state", int'(dut.state), int'(S_IDLE));
    reset_n = 1'b1;
    tick_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Live-zombie cap on the MAX_ACTIVE=2 instance.
    s2_ready = 1'b1;
    s2_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    s2_start = 1'b0;
    for (int i = 0; i < 200 && n2_acc < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cap: spawns before limit", n2_acc, 2);
    seen = 1'b0;
    repeat (40) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (s2_valid) seen = 1'b1;
    end
    checkOutput("cap: spawn_valid stays low", int'(seen), 0);
    checkOutput("cap: active_count at limit", int'(s2_active), 2);
    s2_kill = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    s2_kill = 1'b0;
    checkOutput("cap: active after kill", int'(s2_active), 1);
    checkOutput("cap: killed after kill", int'(s2_killed), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cap: third request raised", int'(s2_valid), 1);
    s2_ready = 1'b0;

    // Wave 1 with the consumer always ready.
    n_acc   = 0;
    gap_chk = 1'b1;
    for (int i = 0; i < 4; i++) lane_q.push_back(3'(i));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2000 && n_acc < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    gap_chk = 1'b0;
    checkOutput("wave1 spawn count", n_acc, 4);
    checkOutput("wave1 active_count", int'(active_count), 4);
    checkOutput("wave1 state after spawns", int'(dut.state), int'(S_DRAIN));
    checkOutput("wave1 spawn_valid idle", int'(spawn_valid), 0);
    checkOutput("wave1 wave number", int'(wave), 1);
    checkOutput("wave1 scoreboard drained", lane_q.size(), 0);

    // Kill-driven drain of wave 1, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].st, vecs[i].kl, 1'b0, vecs[i].rdy);
      checkOutput($sformatf("vec%0d active_count", i), int'(active_count), vecs[i].act);
      checkOutput($sformatf("vec%0d zombies_killed", i), int'(zombies_killed), vecs[i].kills);
      checkOutput($sformatf("vec%0d wave", i), int'(wave), vecs[i].wv);
      checkOutput($sformatf("vec%0d wave_done", i), int'(wave_done), int'(vecs[i].done));
    end

    // Wave 2: stalled request, then a same-cycle accept and kill.
    n_acc = 0;
    for (int i = 0; i < 6; i++) lane_q.push_back(3'((4 + i) % NUM_LANES_TB));
    checkOutput("wave2 request pending", int'(spawn_valid), 1);
    checkOutput("wave2 request lane", int'(spawn_lane), int'(lane_q[0]));
    hold_bad = 1'b0;
    repeat (10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (!(spawn_valid === 1'b1 && spawn_lane === lane_q[0])) hold_bad = 1'b1;
    end
    checkOutput("request held while not ready", int'(hold_bad), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wave2 first accept active", int'(active_count), 1);
    checkOutput("spawn_valid falls after accept", int'(spawn_valid), 0);
    for (int i = 0; i < 1000 && !spawn_valid; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wave2 second request", int'(spawn_valid), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("accept+kill active unchanged", int'(active_count), 1);
    checkOutput("accept+kill killed", int'(zombies_killed), 5);
    for (int i = 0; i < 3000 && n_acc < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wave2 spawn count", n_acc, 6);
    checkOutput("wave2 active_count", int'(active_count), 5);
    checkOutput("wave2 state after spawns", int'(dut.state), int'(S_DRAIN));
    checkOutput("wave2 scoreboard drained", lane_q.size(), 0);

    // Kill counter saturation.
    force dut.zombies_killed = 16'hFFFF;
    #1;
    release dut.zombies_killed;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("saturated killed", int'(zombies_killed), 65535);
    checkOutput("saturated kill active", int'(active_count), 4);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wave3 wave_done", int'(wave_done), 1);
    checkOutput("wave3 wave number", int'(wave), 3);
    checkOutput("killed still saturated", int'(zombies_killed), 65535);

    // Breach during cooldown, then restart.
    n_acc = 0;
    lane_q.push_back(3'(0));
    for (int i = 0; i < 100 && n_acc < 1; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("in cooldown before breach", int'(dut.state), int'(S_COOLDOWN));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("breach game_over", int'(game_over), 1);
    checkOutput("breach spawn_valid", int'(spawn_valid), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("kill ignored in OVER", int'(active_count), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart wave", int'(wave), 1);
    checkOutput("restart killed", int'(zombies_killed), 0);
    checkOutput("restart active", int'(active_count), 0);
    checkOutput("restart game_over", int'(game_over), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("kill at zero active", int'(active_count), 0);
    checkOutput("kill at zero killed", int'(zombies_killed), 0);
    checkOutput("restart request raised", int'(spawn_valid), 1);

    // Asynchronous reset drops an in-flight request immediately.
    reset_n = 1'b0;
    #1;
    checkOutput("async reset spawn_valid", int'(spawn_valid), 0);
    checkOutput("async reset wave", int'(wave), 0);
    checkOutput("async reset state", int'(dut.state), int'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zombie_wave_scheduler.md
# zombie_wave_scheduler

Sequences zombie waves for the Plants vs Zombies game: decides when and in which lane the next zombie spawns, keeps the live-zombie count and the kill total, and advances waves once every zombie of the current wave has been killed. It sits between the game-logic/collision block, which reports kills and lawn breaches, and the VGA colour-mapping block, which consumes `zombies_killed` and draws spawned zombies. The block runs off the pixel-domain clock and paces itself with a per-frame tick.

## Interface
- `NUM_LANES`, 5: number of lawn rows. Legal range 4..8.
- `MAX_ACTIVE`, 8: maximum number of zombies alive at once. Legal range 1..15.
- `SPAWN_INTERVAL`, 60: number of frames between spawns.
- `WAVE_SIZE_INIT`, 4: number of zombies in wave 1.

- `clk`  in  1  system/pixel clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins or restarts a game
- `frame_tick`  in  1  one-cycle pulse, once per VGA frame
- `kill`  in  1  one-cycle pulse: one zombie was destroyed
- `breach`  in  1  one-cycle pulse: a zombie reached the house
- `spawn_ready`  in  1  consumer can accept a spawn
- `spawn_valid`  out  1  spawn request pending
- `spawn_lane`  out  3  lane of the pending spawn, 0..NUM_LANES-1
- `active_count`  out  4  zombies currently alive
- `zombies_killed`  out  16  total kills this game, saturating
- `wave`  out  4  current wave number, 1..15 (0 in IDLE)
- `wave_done`  out  1  one-cycle pulse when a wave is cleared
- `game_over`  out  1  level, high in OVER

## Operation
- FSM states are IDLE, SPAWN, COOLDOWN, DRAIN and OVER.
- **IDLE.** On `start`: set `wave` to 1, `remaining` to `WAVE_SIZE_INIT`, clear `zombies_killed` and `active_count`, then go to SPAWN.
- **SPAWN.** Assert `spawn_valid` only while `active_count < MAX_ACTIVE`.
  - Once asserted, `spawn_valid` and `spawn_lane` hold stable until `spawn_valid && spawn_ready`.
  - On accept: `active_count` +1, `remaining` −1, cooldown counter loaded with `SPAWN_INTERVAL`.
  - After accept, go to DRAIN if `remaining` is now 0, otherwise go to COOLDOWN.
- **COOLDOWN.** Decrement the counter on each `frame_tick`. When it reaches 0, go to SPAWN.
- **DRAIN.** When `active_count == 0`:
  - Pulse `wave_done`.
  - If `wave < 15`: `wave` +1, `remaining = WAVE_SIZE_INIT + wave(new)`, go to SPAWN.
  - If `wave == 15`: go to OVER.
- **OVER.** `game_over` is 1. `start` re-initialises exactly as from IDLE.
- **breach** in SPAWN, COOLDOWN or DRAIN goes to OVER next cycle and drops `spawn_valid`. It is ignored in IDLE and OVER.
- **kill**, outside IDLE and OVER:
  - If `active_count > 0`: `active_count` −1 and `zombies_killed` +1, saturating at 16'hFFFF.
  - A kill while `active_count == 0` is ignored entirely.
- Spawn accept and kill in the same cycle: `active_count` is unchanged, `zombies_killed` +1.
- `start` outside IDLE and OVER is ignored.
- Default lane selection is round-robin: it starts at 0, advances by one on each accept, and wraps at `NUM_LANES-1` back to 0.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- `spawn_valid` rises one cycle after entry to SPAWN. The handshake completes on the edge where `spawn_valid && spawn_ready`; `spawn_valid` falls on the next cycle.
- Counter, `active_count` and `zombies_killed` updates are visible one cycle after the input pulse.
- `wave_done` is high for exactly one cycle, and in that same cycle `wave` shows the new value.
- Cooldown lasts exactly `SPAWN_INTERVAL` frame ticks after the accept. A `frame_tick` in the accept cycle is not counted.
- Asserting `reset_n` mid-operation immediately returns all state and outputs to reset values, including an in-flight spawn request.

## Configuration
- `ZOMBIE_LFSR_LANE_EN` defined:
  - Lanes come from an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 at reset, that steps every cycle.
  - `spawn_lane = lfsr[2:0]`, minus `NUM_LANES` if that value is ≥ `NUM_LANES`.
  - The lane is sampled when `spawn_valid` rises and then held until accept.
- `ZOMBIE_LFSR_LANE_EN` undefined: round-robin as above, and no LFSR logic is present.

## Structure
- Shared package `pvz_pkg` holds:
  - the state enum `sched_state_t`
  - `LANE_W = 3`
  - `MAX_WAVE = 15`
  - the LFSR seed and tap constants, shared with any other randomised game blocks.
- One sub-module, `zombie_lane_picker`, owns round-robin and LFSR lane selection. Its inputs are `advance` and `sample`; its output is `lane`.

## Test plan
- Reset, then `start`, with `spawn_ready` held at 1 → lanes 0,1,2,3 issued `SPAWN_INTERVAL` frames apart, state DRAIN, `active_count=4`.
- 4 kills in DRAIN → `zombies_killed=4`, `wave_done` pulse, `wave=2`, 6 spawns follow.
- `MAX_ACTIVE=2` and no kills → `spawn_valid` stays low after 2 spawns; one kill → the third spawn issues on the next cycle.
- `spawn_ready=0` for 10 cycles → `spawn_valid` and `spawn_lane` hold steady; same-cycle accept and kill → `active_count` unchanged, `zombies_killed` +1.
- `breach` during COOLDOWN → `game_over=1`, `spawn_valid=0`; `start` → `wave=1`, `zombies_killed=0`.
- Preload `zombies_killed=16'hFFFF`, then a kill → it stays at FFFF. A kill with `active_count=0` → no change.
